// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: FSM state encodings,
// stage-control bit positions and a helper that packs the control vector.
// Optional feature macro (used by pipe_ctrl): PIPE_CTRL_PERF_EN.

`ifndef PIPE_CTRL_DEFINES_SV
`define PIPE_CTRL_DEFINES_SV
`define PIPE_CTRL_ST_RUN         2'd0
`define PIPE_CTRL_ST_MD_WAIT     2'd1
`define PIPE_CTRL_BIT_PC_STALL   4
`define PIPE_CTRL_BIT_IFID_STALL 3
`define PIPE_CTRL_BIT_IFID_FLUSH 2
`define PIPE_CTRL_BIT_IDEX_STALL 1
`define PIPE_CTRL_BIT_IDEX_FLUSH 0
`endif

package pipe_ctrl_pkg;

  localparam int CTRL_W = 5;

  // Pack the five stage controls into the shared bit layout.
  function automatic logic [CTRL_W-1:0] mk_ctrl(
    input logic pc_stall,
    input logic if_id_stall,
    input logic if_id_flush,
    input logic id_ex_stall,
    input logic id_ex_flush
  );
    logic [CTRL_W-1:0] v;
    v = {CTRL_W{1'b0}};
    v[`PIPE_CTRL_BIT_PC_STALL]   = pc_stall;
    v[`PIPE_CTRL_BIT_IFID_STALL] = if_id_stall;
    v[`PIPE_CTRL_BIT_IFID_FLUSH] = if_id_flush;
    v[`PIPE_CTRL_BIT_IDEX_STALL] = id_ex_stall;
    v[`PIPE_CTRL_BIT_IDEX_FLUSH] = id_ex_flush;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard compare: the EX load writes a register that the ID
// instruction reads. Purely combinational; RUN-state gating is done by the caller.

module pipe_hazard_det (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_reg_write,
  output logic       load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 is never a real destination, so a load to it cannot create a hazard.
  always_comb begin
    rs1_hit_s = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit_s = id_use_rs2 && (id_rs2 == ex_rd);
    load_use  = ex_is_load && ex_reg_write && (ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / multi-cycle controller: RUN / MD_WAIT FSM, stage
// stall/flush generation and optional performance counters.
// Optional feature: define PIPE_CTRL_PERF_EN to build stall_cnt/flush_cnt.

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             ex_pc_sel,
  input  logic             ex_md_start,
  input  logic             md_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              md_timeout_r;
  logic              timeout_hit_s;
  logic              load_use_s;
  logic [CTRL_W-1:0] ctrl_s;
  logic              md_busy_s;

  pipe_hazard_det u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_reg_write (ex_reg_write),
    .load_use     (load_use_s)
  );

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= `PIPE_CTRL_ST_RUN;
      wait_cnt_r   <= {WAIT_W{1'b0}};
      md_timeout_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      md_timeout_r <= md_timeout_r | timeout_hit_s;
    end
  end

  // Next state: a mul/div launch only waits when it is neither completing
  // immediately nor being squashed by a taken branch. A done arriving on the
  // last wait cycle counts as a normal completion, not a timeout.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_hit_s  = 1'b0;
    case (state_r)
      `PIPE_CTRL_ST_MD_WAIT: begin
        if (md_done) begin
          state_nxt_s    = `PIPE_CTRL_ST_RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s    = `PIPE_CTRL_ST_RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
          timeout_hit_s  = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      default: begin
        // RUN and the unused encodings behave as RUN.
        if (ex_md_start && !md_done && !ex_pc_sel) begin
          state_nxt_s = `PIPE_CTRL_ST_MD_WAIT;
        end else begin
          state_nxt_s = `PIPE_CTRL_ST_RUN;
        end
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Stage controls: MD_WAIT freezes everything, then branch flush, then load-use bubble.
  always_comb begin
    ctrl_s    = {CTRL_W{1'b0}};
    md_busy_s = 1'b0;
    if (sys_rst) begin
      ctrl_s    = {CTRL_W{1'b0}};
      md_busy_s = 1'b0;
    end else begin
      case (state_r)
        `PIPE_CTRL_ST_MD_WAIT: begin
          ctrl_s    = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
          md_busy_s = 1'b1;
        end
        default: begin
          if (ex_pc_sel) begin
            ctrl_s = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
          end else if (load_use_s) begin
            ctrl_s = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
          end else begin
            ctrl_s = {CTRL_W{1'b0}};
          end
        end
      endcase
    end
  end

  assign pc_stall    = ctrl_s[`PIPE_CTRL_BIT_PC_STALL];
  assign if_id_stall = ctrl_s[`PIPE_CTRL_BIT_IFID_STALL];
  assign if_id_flush = ctrl_s[`PIPE_CTRL_BIT_IFID_FLUSH];
  assign id_ex_stall = ctrl_s[`PIPE_CTRL_BIT_IDEX_STALL];
  assign id_ex_flush = ctrl_s[`PIPE_CTRL_BIT_IDEX_FLUSH];
  assign md_busy     = md_busy_s;
  assign md_timeout  = md_timeout_r;
  assign state       = state_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall/flush event counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (MD_TIMEOUT=8, CNT_W=4).
// Driver pushes hand-computed expectations per cycle; monitor pops at negedge.

module tb_pipe_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_reg_write;
  logic       ex_pc_sel, ex_md_start, md_done;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       md_busy, md_timeout;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_pc_sel(ex_pc_sel), .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .md_busy(md_busy), .md_timeout(md_timeout), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // bit4..0 = pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush
  localparam logic [4:0] C0    = 5'b00000;
  localparam logic [4:0] S_ALL = 5'b11010;
  localparam logic [4:0] LU    = 5'b11001;
  localparam logic [4:0] BR    = 5'b00101;

  typedef struct {
    logic [4:0] ctrl;
    logic [1:0] st;
    logic       busy;
    logic       to;
    logic [3:0] sc;
    logic [3:0] fc;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;
  logic [3:0] m_sc = 4'd0;
  logic [3:0] m_fc = 4'd0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e   = exp_q.pop_front();
      got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush};
      checks = checks + 1;
      if (got !== e.ctrl) begin
        errors = errors + 1;
        $display("FAIL ctrl step=%0d got=%b exp=%b", e.id, got, e.ctrl);
      end
      checks = checks + 1;
      if ({state, md_busy, md_timeout} !== {e.st, e.busy, e.to}) begin
        errors = errors + 1;
        $display("FAIL fsm step=%0d got state=%0d busy=%b to=%b exp state=%0d busy=%b to=%b",
                 e.id, state, md_busy, md_timeout, e.st, e.busy, e.to);
      end
      checks = checks + 1;
      if (stall_cnt !== e.sc) begin
        errors = errors + 1;
        $display("FAIL stall_cnt step=%0d got=%0d exp=%0d", e.id, stall_cnt, e.sc);
      end
      checks = checks + 1;
      if (flush_cnt !== e.fc) begin
        errors = errors + 1;
        $display("FAIL flush_cnt step=%0d got=%0d exp=%0d", e.id, flush_cnt, e.fc);
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_reg_write = 1'b0;
    ex_pc_sel = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
  endtask

  task automatic lu_inputs();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  // Issue one cycle: queue its expectation, advance counter model, step clock.
  task automatic cyc(input logic [4:0] c, input logic [1:0] st, input logic busy, input logic to);
    exp_t e;
    e.ctrl = c; e.st = st; e.busy = busy; e.to = to; e.id = n_step;
`ifdef PIPE_CTRL_PERF_EN
    e.sc = m_sc; e.fc = m_fc;
`else
    e.sc = 4'd0; e.fc = 4'd0;
`endif
    exp_q.push_back(e);
    n_step = n_step + 1;
    if (sys_rst) begin
      m_sc = 4'd0; m_fc = 4'd0;
    end else begin
      if (c[4] && m_sc != 4'hF) m_sc = m_sc + 4'd1;
      if (c[2] && m_fc != 4'hF) m_fc = m_fc + 4'd1;
    end
    @(posedge sys_clk); #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    idle();
    @(posedge sys_clk); @(posedge sys_clk); #1;

    // Reset gates controls even with a branch pending.
    ex_pc_sel = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b0);
    sys_rst = 1'b0; idle(); cyc(C0, 2'd0, 1'b0, 1'b0);

    // Load-use on rs2: one bubble, then ex_rd=0 gives nothing.
    lu_inputs(); cyc(LU, 2'd0, 1'b0, 1'b0);
    idle(); cyc(C0, 2'd0, 1'b0, 1'b0);
    lu_inputs(); ex_rd = 5'd0; id_rs2 = 5'd0; cyc(C0, 2'd0, 1'b0, 1'b0);

    // Load-use on rs1, then use flag off, then no reg write.
    idle(); ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    cyc(LU, 2'd0, 1'b0, 1'b0);
    id_use_rs1 = 1'b0; cyc(C0, 2'd0, 1'b0, 1'b0);
    id_use_rs1 = 1'b1; ex_reg_write = 1'b0; cyc(C0, 2'd0, 1'b0, 1'b0);

    // Branch beats load-use.
    idle(); lu_inputs(); ex_pc_sel = 1'b1; cyc(BR, 2'd0, 1'b0, 1'b0);

    // Start+done same cycle, then stray done in RUN, then start squashed by branch.
    idle(); ex_md_start = 1'b1; md_done = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b0);
    idle(); md_done = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b0);
    idle(); ex_md_start = 1'b1; ex_pc_sel = 1'b1; cyc(BR, 2'd0, 1'b0, 1'b0);
    idle(); cyc(C0, 2'd0, 1'b0, 1'b0);

    // Mul/div with done on the 6th wait cycle; branch/hazard ignored while waiting.
    ex_md_start = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 1) ex_pc_sel = 1'b1;
      if (i == 2) lu_inputs();
      cyc(S_ALL, 2'd1, 1'b1, 1'b0);
    end
    idle(); md_done = 1'b1; cyc(S_ALL, 2'd1, 1'b1, 1'b0);
    idle(); cyc(C0, 2'd0, 1'b0, 1'b0);

    // Timeout after 8 wait cycles; flag is sticky.
    ex_md_start = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 8; i++) cyc(S_ALL, 2'd1, 1'b1, 1'b0);
    cyc(C0, 2'd0, 1'b0, 1'b1);
    cyc(C0, 2'd0, 1'b0, 1'b1);

    // Reset on the 3rd wait cycle.
    ex_md_start = 1'b1; cyc(C0, 2'd0, 1'b0, 1'b1);
    idle();
    cyc(S_ALL, 2'd1, 1'b1, 1'b1);
    cyc(S_ALL, 2'd1, 1'b1, 1'b1);
    sys_rst = 1'b1; cyc(C0, 2'd1, 1'b0, 1'b1);
    sys_rst = 1'b0; cyc(C0, 2'd0, 1'b0, 1'b0);

    // Saturation: 20 stall cycles, then one flush.
    lu_inputs();
    for (int i = 0; i < 20; i++) cyc(LU, 2'd0, 1'b0, 1'b0);
    idle(); cyc(C0, 2'd0, 1'b0, 1'b0);
    ex_pc_sel = 1'b1; cyc(BR, 2'd0, 1'b0, 1'b0);
    idle(); cyc(C0, 2'd0, 1'b0, 1'b0);

    @(negedge sys_clk); #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
